// File: rtl/mem_access_stage_if.sv
// Bundle, data-memory and writeback signals of the memory-access stage.
// The "slave" modport is the stage itself; "master" is the surrounding pipeline and memory.
interface mem_access_stage_if;
  // Upstream X->M bundle
  logic        valid_i;
  logic        ready_o;
  logic [63:0] result_i;
  logic [31:0] MuxRes_i;
  logic [3:0]  rd_i;
  logic        RegWrite_i;
  logic        MemWrite_i;
  logic        MemRead_i;
  logic        MemToReg_i;

  // Data-memory port
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [63:0] dmem_addr_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_gnt_i;
  logic        dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;

  // Downstream M->W bundle
  logic        valid_o;
  logic        ready_i;
  logic [63:0] wb_data_o;
  logic [3:0]  rd_o;
  logic        RegWrite_o;

  modport slave (
    input  valid_i, result_i, MuxRes_i, rd_i,
    input  RegWrite_i, MemWrite_i, MemRead_i, MemToReg_i,
    output ready_o,
    output dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o,
    input  dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i,
    output valid_o, wb_data_o, rd_o, RegWrite_o,
    input  ready_i
  );

  modport master (
    output valid_i, result_i, MuxRes_i, rd_i,
    output RegWrite_i, MemWrite_i, MemRead_i, MemToReg_i,
    input  ready_o,
    input  dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o,
    output dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i,
    input  valid_o, wb_data_o, rd_o, RegWrite_o,
    output ready_i
  );
endinterface

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: takes one X->M bundle, runs an optional load/store
// on the data-memory port, then holds the writeback bundle until downstream takes it.
module mem_access_stage #(
  parameter bit ClearDataOnReset = 1'b0
) (
  input  logic               clk_i,
  input  logic               reset_ni,
  mem_access_stage_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP,
    OUT
  } state_e;

  state_e      state_q, state_d;
  logic [63:0] result_q, result_d;
  logic [31:0] muxres_q, muxres_d;
  logic [3:0]  rd_q, rd_d;
  logic        regwrite_q, regwrite_d;
  logic        memwrite_q, memwrite_d;
  logic        memtoreg_q, memtoreg_d;
  logic [63:0] wbdata_q, wbdata_d;
  logic        accept;

  // OUT can hand its bundle downstream and take a new one in the same cycle.
  assign bus.ready_o = reset_ni & ((state_q == IDLE) | ((state_q == OUT) & bus.ready_i));
  assign accept      = bus.valid_i & bus.ready_o;

  always_comb begin
    state_d    = state_q;
    result_d   = result_q;
    muxres_d   = muxres_q;
    rd_d       = rd_q;
    regwrite_d = regwrite_q;
    memwrite_d = memwrite_q;
    memtoreg_d = memtoreg_q;
    wbdata_d   = wbdata_q;

    if (accept) begin
      result_d   = bus.result_i;
      muxres_d   = bus.MuxRes_i;
      rd_d       = bus.rd_i;
      regwrite_d = bus.RegWrite_i;
      memwrite_d = bus.MemWrite_i;
      memtoreg_d = bus.MemToReg_i;
      wbdata_d   = bus.result_i;
      if (bus.MemWrite_i | bus.MemRead_i) begin
        state_d = REQ;
      end else begin
        state_d = OUT;
      end
    end else begin
      case (state_q)
        IDLE: state_d = IDLE;
        // A store with MemRead also set is still a store and never waits for rvalid.
        REQ: begin
          if (bus.dmem_gnt_i) begin
            state_d = memwrite_q ? OUT : RESP;
          end
        end
        RESP: begin
          if (bus.dmem_rvalid_i) begin
            state_d  = OUT;
            wbdata_d = memtoreg_q ? {{32{bus.dmem_rdata_i[31]}}, bus.dmem_rdata_i} : result_q;
          end
        end
        OUT: begin
          if (bus.ready_i) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Data registers are left untouched by reset unless ClearDataOnReset is set.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      if (ClearDataOnReset) begin
        result_q   <= '0;
        muxres_q   <= '0;
        rd_q       <= '0;
        regwrite_q <= 1'b0;
        memwrite_q <= 1'b0;
        memtoreg_q <= 1'b0;
        wbdata_q   <= '0;
      end
    end else begin
      result_q   <= result_d;
      muxres_q   <= muxres_d;
      rd_q       <= rd_d;
      regwrite_q <= regwrite_d;
      memwrite_q <= memwrite_d;
      memtoreg_q <= memtoreg_d;
      wbdata_q   <= wbdata_d;
    end
  end

  assign bus.dmem_req_o   = (state_q == REQ);
  assign bus.dmem_we_o    = memwrite_q;
  assign bus.dmem_addr_o  = result_q;
  assign bus.dmem_wdata_o = muxres_q;

  assign bus.valid_o    = (state_q == OUT);
  assign bus.wb_data_o  = wbdata_q;
  assign bus.rd_o       = rd_q;
  assign bus.RegWrite_o = regwrite_q;

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-access stage of the pipelined CPU, the consumer of the execute/memory (X→M) pipeline register. It accepts one X→M bundle at a time over a valid/ready handshake and runs a load or store on the data-memory port with a req/gnt/rvalid protocol. It then forms the writeback value and presents it to the memory/writeback register over a second valid/ready handshake. ALU-only bundles pass through with single-cycle latency and full throughput.

## Interface
- ClearDataOnReset, 0: when 1, all captured data/output registers are zeroed on reset; when 0, only control state is reset.
- clk_i  in  1  clock; all state updates on the rising edge.
- reset_ni  in  1  reset; synchronous, active-low.
- valid_i  in  1  upstream bundle valid.
- ready_o  out  1  stage accepts a bundle this cycle.
- result_i  in  64  ALU result; this is the memory address for loads and stores.
- MuxRes_i  in  32  store data.
- rd_i  in  4  destination register.
- RegWrite_i, MemWrite_i, MemRead_i, MemToReg_i  in  1 each  control bits.
- dmem_req_o  out  1  memory request.
- dmem_we_o  out  1  1 = store, 0 = load.
- dmem_addr_o  out  64  address; equals the captured result_i, low bits unmodified.
- dmem_wdata_o  out  32  store data.
- dmem_gnt_i  in  1  request accepted.
- dmem_rvalid_i  in  1  load data valid.
- dmem_rdata_i  in  32  load data.
- valid_o  out  1  writeback bundle valid.
- ready_i  in  1  downstream accepts the bundle.
- wb_data_o  out  64  writeback value.
- rd_o  out  4  destination register.
- RegWrite_o  out  1  register-file write enable.

## Operation
- FSM states: IDLE, REQ, RESP, OUT. Reset state is IDLE.
- Accept condition: valid_i & ready_o.
  - ready_o = (state==IDLE) | (state==OUT & ready_i).
  - ready_o is forced to 0 while reset_ni=0.
- On accept, capture result, MuxRes, rd, and the four control bits.
  - If MemWrite or MemRead is set, go to REQ. When both are set, MemWrite wins and the op is a store.
  - Otherwise compute wb_data and go to OUT.
- REQ:
  - dmem_req_o=1; dmem_we_o, dmem_addr_o, dmem_wdata_o are driven from captured values and held stable until gnt.
  - On dmem_gnt_i: a store goes to OUT; a load goes to RESP.
- RESP:
  - dmem_req_o=0. Wait for dmem_rvalid_i.
  - On rvalid, wb_data = sign-extend(dmem_rdata_i) to 64 bits when MemToReg=1, else result. Go to OUT.
- OUT:
  - valid_o=1; wb_data_o, rd_o, RegWrite_o are held stable.
  - On ready_i with a new accept, take the new bundle and branch exactly as from IDLE.
  - On ready_i without an accept, go to IDLE.
- wb_data for non-load ops = result.
- Stores forward RegWrite as captured; this is normally 0.
- rvalid is expected only for loads. rvalid in IDLE, REQ, or OUT is ignored.
- dmem_rvalid_i in the same cycle as dmem_gnt_i is ignored; the earliest legal rvalid is the cycle after gnt.
- Reset in any state:
  - Next state is IDLE; valid_o=0 and dmem_req_o=0 from the next cycle.
  - An outstanding request is abandoned, and a late rvalid is ignored.
  - Data registers are cleared only when ClearDataOnReset=1.

## Timing
- Reset values of outputs: valid_o=0, dmem_req_o=0, ready_o=0 during reset and 1 after release.
  - With ClearDataOnReset=1: dmem_we_o=0, dmem_addr_o=0, dmem_wdata_o=0, wb_data_o=0, rd_o=0, RegWrite_o=0.
  - With ClearDataOnReset=0: data outputs are undefined until the first capture.
- ALU op: accepted at edge T, valid_o from T+1. Back-to-back ALU ops with ready_i=1 sustain 1 bundle per cycle.
- Load: dmem_req_o from T+1. With gnt at T+1 and rvalid at T+2, valid_o is at T+3; each added gnt/rvalid wait adds one cycle.
- Store: with gnt at T+1, valid_o is at T+2.
- Outputs are all registered from state and data registers, except ready_o, which depends combinationally on ready_i in OUT.

## Test plan
- Reset: reset_ni=0 for 3 cycles with valid_i=1 -> valid_o=0, dmem_req_o=0, ready_o=0. Release -> ready_o=1 and no bundle captured.
- ALU stream: 4 bundles, result=0x1234+i, RegWrite=1, MemToReg=0, ready_i=1 -> valid_o every cycle from T+1, wb_data_o=0x1234..0x1237 in order, dmem_req_o never asserted.
- Load with waits: addr 0x100, MemRead=MemToReg=1, gnt 2 cycles after req, rvalid 1 cycle after gnt, rdata=0x8000_0001 -> addr held at 0x100 throughout REQ; wb_data_o=0xFFFF_FFFF_8000_0001 with valid_o the cycle after rvalid.
- Store: addr 0x200, MuxRes=0xDEADBEEF, gnt immediate -> single req cycle with dmem_we_o=1, wdata=0xDEADBEEF; valid_o next cycle with RegWrite_o=0; no wait for rvalid.
- Backpressure: ready_i=0 for 5 cycles in OUT -> ready_o=0 and outputs stable. Then ready_i=1 with valid_i=1 -> new bundle accepted that same cycle.
- Reset mid-load: reset in RESP, rvalid arrives 2 cycles after release -> state IDLE, valid_o stays 0, rvalid ignored.
